// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: pulls words out of a fixed-latency FIFO and presents them
// as a valid/ready stream. Reads are credit-limited so that every word already
// requested always has a slot in the local output buffer.
module fifo_read_streamer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic [15:0]           word_count
);

    localparam int unsigned BUF_DEPTH = LATENCY + 2;
    localparam int unsigned CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned OCC_W     = CNT_W + 1;

    // Elaboration guard: the shift register below needs at least two stages
    generate
        if (LATENCY < 2) begin : g_latency_check
            $error("fifo_read_streamer: LATENCY must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    logic [LATENCY-1:0]    inflight_vld;
    logic [CNT_W-1:0]      inflight_cnt;
    logic [CNT_W-1:0]      buf_cnt;
    logic [CNT_W-1:0]      buf_cnt_next;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_inc;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] out_data_next;
    logic [OCC_W-1:0]      occupancy;
    logic                  credit_ok;
    logic                  capture;
    logic                  pop;

    // Circular pointer advance, wrapping at BUF_DEPTH (not necessarily a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign capture    = inflight_vld[LATENCY-1];
    assign pop        = out_valid & out_ready;
    assign rd_ptr_inc = ptr_inc(rd_ptr);

    // Number of reads issued whose data has not yet been captured
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < int'(LATENCY); i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(inflight_vld[i]);
        end
    end

    // Credit check uses registered counts only; a same-cycle pop earns no credit
    always_comb begin
        occupancy = OCC_W'(inflight_cnt) + OCC_W'(buf_cnt);
        credit_ok = (occupancy < OCC_W'(BUF_DEPTH));
    end

    // Read strobe: must react to fifo_empty in the same cycle to avoid reading an empty FIFO
    assign fifo_read = ~reset & (state == RUN) & enable & ~fifo_empty & credit_ok;

    // Control FSM; busy is kept equal to (state != IDLE)
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (enable) begin
                        state <= RUN;
                    end else if ((inflight_cnt == '0) && (buf_cnt == '0)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // In-flight tracker: bit LATENCY-1 marks the cycle the FIFO data is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_vld <= '0;
        end else begin
            inflight_vld <= {inflight_vld[LATENCY-2:0], fifo_read};
        end
    end

    // Buffer storage; contents need no reset since count and pointers gate use
    always_ff @(posedge clk) begin
        if (!reset && capture) begin
            mem[wr_ptr] <= fifo_read_data;
        end
    end

    // Buffer occupancy after this cycle's capture and pop
    always_comb begin
        buf_cnt_next = buf_cnt;
        unique case ({capture, pop})
            2'b10:   buf_cnt_next = buf_cnt + CNT_W'(1);
            2'b01:   buf_cnt_next = buf_cnt - CNT_W'(1);
            default: buf_cnt_next = buf_cnt;
        endcase
    end

    // Next head word: the next stored entry on pop, or the captured word when it lands in an empty slot
    always_comb begin
        out_data_next = out_data;
        if (pop && (buf_cnt > CNT_W'(1))) begin
            out_data_next = mem[rd_ptr_inc];
        end else if (capture && ((buf_cnt == '0) || (pop && (buf_cnt == CNT_W'(1))))) begin
            out_data_next = fifo_read_data;
        end
    end

    // Buffer pointers, count and registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            buf_cnt   <= buf_cnt_next;
            out_valid <= (buf_cnt_next != '0);
            out_data  <= out_data_next;
        end
    end

    // Completed-transfer counter, free-running wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
        end else if (pop) begin
            word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Bench for fifo_read_streamer: a queue-based FIFO with fixed read latency feeds
// the DUT, and a word-level model (expected order queue plus buffer occupancy)
// is compared against the stream outputs every cycle.
module tb_fifo_read_streamer;

    localparam int unsigned DW  = 8;
    localparam int unsigned L   = 2;
    localparam int unsigned BUF = L + 2;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_read;
    logic [DW-1:0] fifo_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic [15:0]   word_count;

    fifo_read_streamer #(.DATA_WIDTH(DW), .LATENCY(L)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_read      (fifo_read),
        .fifo_read_data (fifo_read_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .busy           (busy),
        .word_count     (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            cyc    = 0;

    // FIFO model: source words, data return delay line and its valid tags
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] dl [L];
    logic [L-1:0]  live;

    // Stream model: words in read order, buffer occupancy, transfer count
    logic [DW-1:0] exp_q[$];
    int            occ;
    logic [15:0]   wc_m;
    bit            model_on;
    bit            hold_prev;
    logic [DW-1:0] hold_data;
    bit            rd_s;
    bit            rst_s;

    // Samples of the most recent cycle, for directed checks
    logic          s_rd, s_valid, s_busy, s_rdy;
    logic [DW-1:0] s_data;
    logic [15:0]   s_wc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one cycle
    task automatic mon();
        int            inf;
        bit            cap;
        bit            pop;
        logic [DW-1:0] e;
        s_rd    = fifo_read;
        s_valid = out_valid;
        s_data  = out_data;
        s_busy  = busy;
        s_wc    = word_count;
        s_rdy   = out_ready;
        rd_s    = s_rd;
        rst_s   = reset;
        inf = 0;
        for (int i = 0; i < int'(L); i++) inf += int'(live[i]);
        if (model_on) begin
            chk("rd_when_empty", 32'(s_rd & fifo_empty), 32'd0);
            chk("out_valid", 32'(s_valid), 32'(occ != 0));
            chk("word_count", 32'(s_wc), 32'(wc_m));
            chk("credit_limit", 32'((occ + inf) <= int'(BUF)), 32'd1);
            if (hold_prev) chk("hold_data", 32'(s_data), 32'(hold_data));
            if (!reset && occ != 0 && s_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("exp_available", 32'd0, 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(s_data), 32'(e));
                end
            end
        end
        if (reset) begin
            occ       = 0;
            wc_m      = 16'd0;
            exp_q.delete();
            hold_prev = 1'b0;
            model_on  = 1'b1;
        end else if (model_on) begin
            cap = live[L-1];
            pop = (occ != 0) && s_rdy;
            occ = occ + int'(cap) - int'(pop);
            if (pop) wc_m = wc_m + 16'd1;
            hold_prev = s_valid && !s_rdy;
            hold_data = s_data;
        end
    endtask

    // FIFO behaviour at the clock edge: serve the sampled strobe, shift the return line
    task automatic fifo_upd();
        logic [DW-1:0] w;
        for (int i = int'(L) - 1; i > 0; i--) begin
            dl[i]   = dl[i-1];
            live[i] = live[i-1];
        end
        if (rd_s && src_q.size() > 0) begin
            w = src_q.pop_front();
            exp_q.push_back(w);
            dl[0]   = w;
            live[0] = 1'b1;
        end else begin
            dl[0]   = 8'hEE;
            live[0] = 1'b0;
        end
        if (rst_s) live = '0;
        fifo_read_data = dl[L-1];
        fifo_empty     = (src_q.size() == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon();
        @(posedge clk);
        #1;
        fifo_upd();
    endtask

    task automatic load(input int n, input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int i = 0; i < n; i++) src_q.push_back(DW'(base + DW'(i) * step));
        fifo_empty = (src_q.size() == 0);
    endtask

    initial begin
        logic [9:0]    rd_log;
        logic [9:0]    v_log;
        logic [DW-1:0] d_log [10];
        int            t;
        int            n;
        int            last_v;
        int            bf;
        int            c_a;
        int            c_b;

        reset = 1'b1; enable = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1;
        fifo_read_data = '0; live = '0; occ = 0; wc_m = 16'd0;
        model_on = 1'b0; hold_prev = 1'b0; rd_s = 1'b0; rst_s = 1'b0;
        for (int i = 0; i < int'(L); i++) dl[i] = 8'hEE;

        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            enable         = 1'($urandom);
            out_ready      = 1'($urandom);
            fifo_empty     = 1'($urandom);
            fifo_read_data = DW'($urandom);
            tick();
        end
        reset = 1'b0; enable = 1'b0; out_ready = 1'b0;
        tick();
        chk("rst_fifo_read", 32'(s_rd), 32'd0);
        chk("rst_out_valid", 32'(s_valid), 32'd0);
        chk("rst_out_data", 32'(s_data), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_word_count", 32'(s_wc), 32'd0);

        // Four words, free-flowing sink: strobes cycles 0-3, data cycles 3-6
        load(4, 8'h11, 8'h01);
        out_ready = 1'b1; enable = 1'b1;
        tick();
        t = 0;
        while (!s_rd && t < 10) begin tick(); t++; end
        chk("t2_first_strobe", 32'(s_rd), 32'd1);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) tick();
            rd_log[k] = s_rd;
            v_log[k]  = s_valid;
            d_log[k]  = s_data;
        end
        chk("t2_rd_pattern", 32'(rd_log), 32'h00F);
        chk("t2_valid_pattern", 32'(v_log), 32'h078);
        for (int k = 3; k < 7; k++) chk("t2_data", 32'(d_log[k]), 32'(8'h11 + 8'(k - 3)));
        chk("t2_word_count", 32'(s_wc), 32'd4);
        chk("t2_busy", 32'(s_busy), 32'd1);

        // Stalled sink: exactly BUF_DEPTH strobes, then release and drain all ten
        out_ready = 1'b0;
        load(10, 8'hA0, 8'h01);
        n = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (s_rd) n++; end
        chk("t3_strobes_stalled", 32'(n), 32'(BUF));
        chk("t3_rd_stopped", 32'(s_rd), 32'd0);
        chk("t3_valid_stalled", 32'(s_valid), 32'd1);
        chk("t3_head_stalled", 32'(s_data), 32'hA0);
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) tick();
        chk("t3_word_count", 32'(s_wc), 32'd14);
        chk("t3_valid_done", 32'(s_valid), 32'd0);

        // Enable dropped one cycle after two strobes: drain, then go idle
        enable = 1'b0;
        t = 0;
        tick();
        while (s_busy && t < 20) begin tick(); t++; end
        chk("t4_idle_before", 32'(s_busy), 32'd0);
        load(5, 8'h31, 8'h01);
        enable = 1'b1;
        n = 0; t = 0;
        while (n < 2 && t < 10) begin tick(); if (s_rd) n++; t++; end
        chk("t4_two_strobes", 32'(n), 32'd2);
        enable = 1'b0;
        n = 0; last_v = -1; bf = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 1) chk("t4_busy_in_drain", 32'(s_busy), 32'd1);
            if (s_rd) n++;
            if (s_valid) last_v = cyc;
            if (!s_busy && bf < 0) bf = cyc;
        end
        chk("t4_no_strobe_in_drain", 32'(n), 32'd0);
        chk("t4_word_count", 32'(s_wc), 32'd16);
        chk("t4_busy_fall", 32'(bf - last_v), 32'd2);

        // Reset with two reads in flight: returning data must be ignored
        enable = 1'b1;
        n = 0; t = 0;
        while (n < 2 && t < 10) begin tick(); if (s_rd) n++; t++; end
        chk("t5_two_strobes", 32'(n), 32'd2);
        reset = 1'b1; enable = 1'b0;
        tick();
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (s_valid) n++; end
        chk("t5_no_valid_after_reset", 32'(n), 32'd0);
        chk("t5_word_count", 32'(s_wc), 32'd0);
        chk("t5_busy", 32'(s_busy), 32'd0);

        // 65536 back-to-back transfers: one per cycle, counter wraps to zero
        load(65535, 8'h03, 8'h07);
        enable = 1'b1; out_ready = 1'b1;
        c_a = -1; c_b = -1; t = 0;
        while (c_b < 0 && t < 70000) begin
            tick();
            if (s_wc == 16'd1 && c_a < 0) c_a = cyc;
            if (s_wc == 16'hFFFF) c_b = cyc;
            t++;
        end
        chk("t6_reached_ffff", 32'(c_b >= 0), 32'd1);
        chk("t6_throughput", 32'(c_b - c_a), 32'd65534);
        chk("t6_last_valid", 32'(s_valid), 32'd1);
        tick();
        chk("t6_wrap", 32'(s_wc), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("t6_idle_end", 32'(s_busy), 32'd0);
        chk("t6_valid_end", 32'(s_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_read_streamer.md
FIFO_READ_STREAMER -- requirements
Module: fifo_read_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of FIFO read data and stream data.
REQ-002 SHALL have parameter LATENCY, default 2, minimum 2, cycles from FIFO read pulse to valid FIFO read data.
REQ-003 SHALL have localparam BUF_DEPTH = LATENCY + 2, the internal output buffer depth in words.
REQ-004 SHALL have a single clock and a synchronous, active-high reset: clk, reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 enable  input  1  level; 1 = stream words out of the FIFO, 0 = stop and drain.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_read  output  1  one-cycle read strobe to the FIFO, one word per high cycle.
REQ-010 fifo_read_data  input  DATA_WIDTH  FIFO data; valid exactly LATENCY cycles after the strobe cycle.
REQ-011 out_valid  output  1  stream data valid.
REQ-012 out_ready  input  1  stream sink accepts; transfer = out_valid & out_ready.
REQ-013 out_data  output  DATA_WIDTH  stream data, head of buffer.
REQ-014 busy  output  1  state != IDLE.
REQ-015 word_count  output  16  count of completed stream transfers, wraps.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and DRAIN.
REQ-017 IDLE -> RUN when enable=1; RUN -> DRAIN when enable=0; DRAIN -> IDLE when in-flight count = 0 and buffer empty; DRAIN -> RUN when enable=1.
REQ-018 SHALL assert fifo_read only in RUN, with enable=1, fifo_empty=0, and (in-flight + buffered) < BUF_DEPTH, evaluated from registered counts with no credit taken for a same-cycle pop.
REQ-019 SHALL track in-flight reads with a LATENCY-stage valid shift register and capture fifo_read_data into the buffer only in the cycle its stage-LATENCY bit is set.
REQ-020 Buffer SHALL be a circular FIFO of BUF_DEPTH words with registered output (no bypass); first out_valid occurs in cycle LATENCY+1 after a strobe in cycle 0 into an empty buffer.
REQ-021 out_valid SHALL equal (buffer count != 0); out_data SHALL hold the head word and stay stable while out_valid=1 and out_ready=0.
REQ-022 Simultaneous capture and pop SHALL leave buffer count unchanged and preserve order.
REQ-023 Buffer SHALL never overflow or drop a returned word; order out = order read.
REQ-024 With fifo_empty=0 and out_ready=1 held, SHALL sustain one transfer per cycle after initial latency.
REQ-025 word_count SHALL increment by 1 per transfer, 0xFFFF -> 0x0000 wrap.
REQ-026 In DRAIN, no new strobes; in-flight data still captured and buffer still delivered.
REQ-027 Pointers and counts SHALL use modulo-BUF_DEPTH wrap, count width $clog2(BUF_DEPTH+1).

Reset
REQ-028 On reset: state IDLE, fifo_read=0, out_valid=0, out_data=0, busy=0, word_count=0, buffer pointers/count 0, in-flight shift register cleared.
REQ-029 Reset mid-operation SHALL discard in-flight reads; data returning after reset is not captured.

Verification
REQ-030 Assert reset 2 cycles with random inputs -> all outputs 0, state IDLE.
REQ-031 LATENCY=2, FIFO holds 0x11..0x14, enable=1, out_ready=1 -> fifo_read high cycles 0-3, out_valid cycles 3-6 with 0x11..0x14, word_count=4, no read while fifo_empty=1.
REQ-032 out_ready=0, FIFO holds 10 words -> exactly BUF_DEPTH=4 strobes then fifo_read=0; release out_ready -> all 10 words in order, no loss or duplicate.
REQ-033 enable dropped 1 cycle after 2 strobes -> state DRAIN, no further strobes, both words delivered, busy falls the cycle after buffer empties.
REQ-034 reset asserted with 2 reads in flight -> buffer empty, out_valid=0, late fifo_read_data ignored, word_count=0.
REQ-035 Preload word_count path by 65536 transfers -> word_count wraps 0xFFFF -> 0x0000.
